// File: rtl/connect_four_pkg.sv
// Shared types and defaults for the Connect Four board logic.
package connect_four_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    FALL,
    CHECK
  } col_state_t;

  localparam int ROWS_DEF    = 6;
  localparam int WIN_LEN_DEF = 4;

  function automatic logic valid_colour(input logic [1:0] c);
    return (c == RED) || (c == GREEN);
  endfunction

endpackage

// File: rtl/column_run_detect.sv
// Counts same-colour cells downward from a top index and flags a run of at
// least WIN_LEN; shared with the row and diagonal checkers.
module column_run_detect
  import connect_four_pkg::*;
#(
  parameter int   ROWS    = ROWS_DEF,
  parameter int   WIN_LEN = WIN_LEN_DEF,
  localparam int  IDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [2*ROWS-1:0] cells,
  input  logic [IDX_W-1:0]  top,
  input  logic [1:0]        colour,
  output logic              run
);

  int   count;
  logic broken;

  always_comb begin
    count  = 0;
    broken = 1'b0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (r <= int'(top) && !broken) begin
        // An empty colour never forms a run.
        if (colour != EMPTY && cells[2*r +: 2] == colour) begin
          count = count + 1;
        end else begin
          broken = 1'b1;
        end
      end
    end
    run = (count >= WIN_LEN);
  end

endmodule

// File: rtl/connect_four_column.sv
// One board column: accepts drops, animates the falling piece one row per
// tick, commits it to the stack and flags a vertical win.
module connect_four_column
  import connect_four_pkg::*;
#(
  parameter int  ROWS     = ROWS_DEF,
  parameter int  WIN_LEN  = WIN_LEN_DEF,
  localparam int HEIGHT_W = $clog2(ROWS + 1),
  localparam int IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                drop,
  input  logic [1:0]          player,
  input  logic                clear,
  output logic [2*ROWS-1:0]   cells,
  output logic [HEIGHT_W-1:0] height,
  output logic                full,
  output logic                busy,
  output logic                accept,
  output logic                reject,
  output logic                done,
  output logic [1:0]          win
);

  col_state_t          state;
  col_state_t          state_next;
  logic [HEIGHT_W-1:0] pos;
  logic [HEIGHT_W-1:0] height_q;
  logic [1:0]          pcol;
  logic [1:0]          win_q;
  logic [2*ROWS-1:0]   board;
  logic                accept_q;
  logic                reject_q;
  logic                take;
  logic                step_tick;
  logic                landing;
  logic                run;
  logic [IDX_W-1:0]    top_idx;

  assign full      = (height_q == HEIGHT_W'(ROWS));
  assign take      = (state == IDLE) && drop && valid_colour(player) && !full &&
                     (win_q == EMPTY);
  assign step_tick = (state == FALL) && tick;
  assign landing   = step_tick && (pos == height_q);
  assign top_idx   = IDX_W'(height_q - 1'b1);

  column_run_detect #(
    .ROWS    (ROWS),
    .WIN_LEN (WIN_LEN)
  ) u_run (
    .cells  (board),
    .top    (top_idx),
    .colour (pcol),
    .run    (run)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (take) state_next = FALL;
        FALL:    if (landing) state_next = CHECK;
        CHECK:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      board    <= '0;
      height_q <= '0;
      pos      <= '0;
      pcol     <= '0;
      win_q    <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else if (clear) begin
      board    <= '0;
      height_q <= '0;
      pos      <= '0;
      pcol     <= '0;
      win_q    <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      accept_q <= take;
      // A refusal on the landing edge is swallowed so it never overlaps done.
      reject_q <= drop && !take && !landing;
      if (take) begin
        pcol <= player;
        pos  <= HEIGHT_W'(ROWS - 1);
      end
      if (landing) begin
        board[2*int'(pos) +: 2] <= pcol;
        height_q                <= height_q + 1'b1;
      end else if (step_tick) begin
        pos <= pos - 1'b1;
      end
      if (state == CHECK && run) begin
        win_q <= pcol;
      end
    end
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == CHECK);
    win   = win_q;
    cells = board;
    // The win is shown during the check cycle so it appears alongside done.
    if (state == CHECK && run) begin
      win = pcol;
    end
    if (state == FALL) begin
      cells[2*int'(pos) +: 2] = pcol;
    end
  end

  assign height = height_q;
  assign accept = accept_q;
  assign reject = reject_q;

endmodule
